// File: rtl/addr_calcu_pkg.sv
// Shared types and defaults for the address calculator family.
// Result bundle of the inverse (decode) direction.
package addr_calcu_pkg;

  localparam int AW = 8;
  localparam int CW = 2 * AW;
  localparam logic [AW-1:0] BASE = 8'h80;

  typedef struct packed {
    logic [AW-1:0] offset;
    logic [AW-1:0] ptr;
    logic          control;
    logic          match;
    logic          ambig;
    logic          range_err;
  } dec_res_t;

endpackage

// File: rtl/addr_decalcu_cmp.sv
// Stage-2 decode: turns a wide offset and two candidate
// pointers into the recovered pointer/select and status flags.
module addr_decalcu_cmp
  import addr_calcu_pkg::*;
#(
  parameter logic [AW-1:0] PTR_BASE = BASE
) (
  input  logic [CW-1:0] off16_i,
  input  logic [AW-1:0] ptr1_i,
  input  logic [AW-1:0] ptr2_i,
  output dec_res_t      res_o
);

  logic          rerr;
  logic [AW-1:0] off;
  logic [AW-1:0] ptr;
  logic          hit1;
  logic          hit2;

  assign rerr = |off16_i[CW-1:AW];
  assign off  = off16_i[AW-1:0];
  assign ptr  = PTR_BASE - off;
  assign hit1 = (ptr == ptr1_i);
  assign hit2 = (ptr == ptr2_i);

  // ptr1 takes priority; an out-of-range offset never matches
  always_comb begin
    res_o           = '0;
    res_o.offset    = off;
    res_o.ptr       = ptr;
    res_o.range_err = rerr;
    res_o.match     = !rerr && (hit1 || hit2);
    res_o.control   = !rerr && hit1;
    res_o.ambig     = !rerr && hit1 && hit2;
  end

endmodule

// File: rtl/addr_decalcu.sv
// Inverse address calculator: two-stage valid/ready pipe
// recovering pointer/offset/select, plus a miss counter.
module addr_decalcu #(
  parameter int              AW   = addr_calcu_pkg::AW,
  parameter logic [AW-1:0]   BASE = addr_calcu_pkg::BASE,
  parameter int              MCW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*AW-1:0] in_count,
  input  logic [AW-1:0]   in_address,
  input  logic [AW-1:0]   in_b,
  input  logic [AW-1:0]   in_ptr1,
  input  logic [AW-1:0]   in_ptr2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_offset,
  output logic [AW-1:0]   out_ptr,
  output logic            out_control,
  output logic            out_match,
  output logic            out_ambig,
  output logic            out_range_err,
  input  logic            clr_cnt,
  output logic [MCW-1:0]  miss_cnt
);

  import addr_calcu_pkg::dec_res_t;

  localparam int CW = 2 * AW;

  logic          s1_v_q;
  logic [CW-1:0] s1_off_q;
  logic [AW-1:0] s1_p1_q;
  logic [AW-1:0] s1_p2_q;
  logic          s2_v_q;
  dec_res_t      res_q;
  dec_res_t      res_d;
  logic [MCW-1:0] miss_q;
  logic [MCW-1:0] miss_d;

  logic          s2_adv;
  logic [CW-1:0] addr_d;
  logic [CW-1:0] off16_d;

  assign s2_adv   = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_adv;

  assign addr_d  = in_count - {{AW{1'b0}}, in_b};
  assign off16_d = {{AW{1'b0}}, in_address} - addr_d;

  // Stage 1: capture the wide offset and candidates on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_off_q <= '0;
      s1_p1_q  <= '0;
      s1_p2_q  <= '0;
    end else if (in_ready) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_off_q <= off16_d;
        s1_p1_q  <= in_ptr1;
        s1_p2_q  <= in_ptr2;
      end
    end
  end

  addr_decalcu_cmp #(
    .PTR_BASE(BASE)
  ) u_cmp (
    .off16_i(s1_off_q),
    .ptr1_i (s1_p1_q),
    .ptr2_i (s1_p2_q),
    .res_o  (res_d)
  );

  // Stage 2: output register, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q <= 1'b0;
      res_q  <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) res_q <= res_d;
    end
  end

  // Miss counter next state: clear beats a saturating increment
  always_comb begin
    miss_d = miss_q;
    if (clr_cnt) miss_d = '0;
    else if (s2_v_q && out_ready && !res_q.match && (miss_q != '1))
      miss_d = miss_q + 1'b1;
  end

  // Miss counter register
  always_ff @(posedge clk) begin
    if (rst) miss_q <= '0;
    else     miss_q <= miss_d;
  end

  assign out_valid     = s2_v_q;
  assign out_offset    = res_q.offset;
  assign out_ptr       = res_q.ptr;
  assign out_control   = res_q.control;
  assign out_match     = res_q.match;
  assign out_ambig     = res_q.ambig;
  assign out_range_err = res_q.range_err;
  assign miss_cnt      = miss_q;

endmodule

// File: tb/tb_addr_decalcu.sv
// Directed bench for addr_decalcu: decode vectors, handshake,
// miss counter saturation/clear and reset flush.
module tb_addr_decalcu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_count;
  logic [7:0]  in_address;
  logic [7:0]  in_b;
  logic [7:0]  in_ptr1;
  logic [7:0]  in_ptr2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_offset;
  logic [7:0]  out_ptr;
  logic        out_control;
  logic        out_match;
  logic        out_ambig;
  logic        out_range_err;
  logic        clr_cnt;
  logic [7:0]  miss_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  addr_decalcu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_count     (in_count),
    .in_address   (in_address),
    .in_b         (in_b),
    .in_ptr1      (in_ptr1),
    .in_ptr2      (in_ptr2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_offset   (out_offset),
    .out_ptr      (out_ptr),
    .out_control  (out_control),
    .out_match    (out_match),
    .out_ambig    (out_ambig),
    .out_range_err(out_range_err),
    .clr_cnt      (clr_cnt),
    .miss_cnt     (miss_cnt)
  );

  task automatic set_vec(input logic [15:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] p1,
                         input logic [7:0] p2);
    in_count = c; in_address = a; in_b = b; in_ptr1 = p1; in_ptr2 = p2;
  endtask

  task automatic push(input logic [15:0] c, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] p1,
                      input logic [7:0] p2);
    set_vec(c, a, b, p1, p2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    set_vec(16'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    tick(3);
    rst = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || miss_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctl: valid=%b ready=%b miss=%h want 0 1 00", out_valid, in_ready, miss_cnt);
    end
    n_chk++;
    if (out_offset !== 8'h00 || out_ptr !== 8'h00 || out_match !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: off=%h ptr=%h match=%b want 00 00 0", out_offset, out_ptr, out_match);
    end
  endtask

  task automatic test_basic;
    push(16'h0045, 8'h90, 8'h05, 8'h30, 8'h11);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat1: out_valid=%b want 0", out_valid);
    end
    tick(1);
    n_chk++;
    if (out_valid !== 1'b1 || out_offset !== 8'h50 || out_ptr !== 8'h30 ||
        out_control !== 1'b1 || out_match !== 1'b1 || out_ambig !== 1'b0 ||
        out_range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic: v=%b off=%h ptr=%h c=%b m=%b a=%b r=%b want 1 50 30 1 1 0 0",
               out_valid, out_offset, out_ptr, out_control, out_match, out_ambig, out_range_err);
    end
    tick(2);
  endtask

  task automatic test_wrap;
    push(16'h008F, 8'h10, 8'hFF, 8'h44, 8'h00);
    tick(1);
    n_chk++;
    if (out_valid !== 1'b1 || out_offset !== 8'h80 || out_ptr !== 8'h00 ||
        out_control !== 1'b0 || out_match !== 1'b1 || out_range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: v=%b off=%h ptr=%h c=%b m=%b r=%b want 1 80 00 0 1 0",
               out_valid, out_offset, out_ptr, out_control, out_match, out_range_err);
    end
    tick(2);
    n_chk++;
    if (miss_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_miss: miss_cnt=%h want 00", miss_cnt);
    end
  endtask

  task automatic test_range;
    push(16'h1000, 8'h00, 8'h00, 8'h80, 8'h80);
    tick(1);
    n_chk++;
    if (out_valid !== 1'b1 || out_range_err !== 1'b1 || out_match !== 1'b0 ||
        out_control !== 1'b0 || out_offset !== 8'h00 || out_ptr !== 8'h80) begin
      n_fail++;
      $display("FAIL range: v=%b r=%b m=%b c=%b off=%h ptr=%h want 1 1 0 0 00 80",
               out_valid, out_range_err, out_match, out_control, out_offset, out_ptr);
    end
    n_chk++;
    if (miss_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL range_pre: miss_cnt=%h want 00", miss_cnt);
    end
    tick(1);
    n_chk++;
    if (miss_cnt !== 8'h01 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL range_post: miss_cnt=%h valid=%b want 01 0", miss_cnt, out_valid);
    end
  endtask

  task automatic test_ambig;
    push(16'h0045, 8'h90, 8'h05, 8'h30, 8'h30);
    tick(1);
    n_chk++;
    if (out_control !== 1'b1 || out_match !== 1'b1 || out_ambig !== 1'b1 ||
        out_ptr !== 8'h30) begin
      n_fail++;
      $display("FAIL ambig: c=%b m=%b a=%b ptr=%h want 1 1 1 30",
               out_control, out_match, out_ambig, out_ptr);
    end
    tick(2);
    n_chk++;
    if (miss_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL ambig_miss: miss_cnt=%h want 01", miss_cnt);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    push(16'h0045, 8'h90, 8'h05, 8'h30, 8'h11);
    push(16'h008F, 8'h10, 8'hFF, 8'h44, 8'h00);
    set_vec(16'h1000, 8'h00, 8'h00, 8'h00, 8'h00);
    in_valid = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: in_ready=%b want 0", in_ready);
    end
    tick(2);
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out_offset !== 8'h50 || out_ptr !== 8'h30 ||
        out_control !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: v=%b off=%h ptr=%h c=%b want 1 50 30 1",
               out_valid, out_offset, out_ptr, out_control);
    end
    out_ready = 1'b1;
    tick(1);
    n_chk++;
    if (out_valid !== 1'b1 || out_offset !== 8'h80 || out_ptr !== 8'h00 ||
        out_control !== 1'b0 || out_match !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: v=%b off=%h ptr=%h c=%b m=%b want 1 80 00 0 1",
               out_valid, out_offset, out_ptr, out_control, out_match);
    end
    tick(1);
    n_chk++;
    if (out_valid !== 1'b0 || miss_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL bp_drain: v=%b miss=%h want 0 01", out_valid, miss_cnt);
    end
  endtask

  task automatic test_saturate;
    set_vec(16'h1000, 8'h00, 8'h00, 8'h00, 8'h00);
    in_valid = 1'b1;
    tick(300);
    in_valid = 1'b0;
    tick(4);
    n_chk++;
    if (miss_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL saturate: miss_cnt=%h want ff", miss_cnt);
    end
  endtask

  task automatic test_clear;
    push(16'h1000, 8'h00, 8'h00, 8'h00, 8'h00);
    tick(1);
    n_chk++;
    if (out_valid !== 1'b1 || out_match !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_pre: v=%b m=%b want 1 0", out_valid, out_match);
    end
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    n_chk++;
    if (miss_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_wins: miss_cnt=%h want 00", miss_cnt);
    end
    push(16'h1000, 8'h00, 8'h00, 8'h00, 8'h00);
    tick(3);
    n_chk++;
    if (miss_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL clr_recount: miss_cnt=%h want 01", miss_cnt);
    end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    push(16'h0045, 8'h90, 8'h05, 8'h30, 8'h11);
    push(16'h008F, 8'h10, 8'hFF, 8'h44, 8'h00);
    n_chk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_full: ready=%b valid=%b want 0 1", in_ready, out_valid);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || miss_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL mrst: valid=%b ready=%b miss=%h want 0 1 00", out_valid, in_ready, miss_cnt);
    end
    out_ready = 1'b1;
    tick(3);
    n_chk++;
    if (out_valid !== 1'b0 || miss_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL mrst_flush: valid=%b miss=%h want 0 00", out_valid, miss_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_range;
    test_ambig;
    test_back_to_back;
    test_saturate;
    test_clear;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
